axi4lite_master: RTL

Single-transaction AXI4-Lite master engine that turns simple start/idle command requests into AXI4-Lite read and write bursts of length one. It is the initiator-side counterpart of the team's AXI4-Lite slave register blocks. It sits between control FSMs (bring-up sequencers, register pokers) and an AXI interconnect feeding those slaves. The read and write channels are independent and may be in flight at the same time.

---
 rtl/axi4lite_master.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/axi4lite_master.sv
// axi4lite_master
//   Single-beat AXI4-Lite initiator. A control FSM pulses AMCI_WRITE or
//   AMCI_READ while the matching idle flag is high. The engine then runs
//   one AXI4-Lite write (AW + W + B) or read (AR + R) and returns the
//   response on the AMCI_* side. The read and write engines are fully
//   independent and may be in flight at the same time.
//
// Ports
//   AXI_ACLK, AXI_ARESETN    clock, asynchronous active-low reset
//   AMCI_WADDR/WDATA/WRITE   write command (sampled while AMCI_WIDLE=1)
//   AMCI_WRESP, AMCI_WIDLE   last write response, write engine free
//   AMCI_RADDR/READ          read command (sampled while AMCI_RIDLE=1)
//   AMCI_RDATA/RRESP/RIDLE   last read data/response, read engine free
//   M_AXI_*                  AXI4-Lite master channels AW, W, B, AR, R
//   M_AXI_DATA_WIDTH must be 32 or 64.
module axi4lite_master #(
  parameter int M_AXI_DATA_WIDTH = 32,
  parameter int M_AXI_ADDR_WIDTH = 32
) (
  input  logic                            AXI_ACLK,
  input  logic                            AXI_ARESETN,
  input  logic [M_AXI_ADDR_WIDTH-1:0]     AMCI_WADDR,
  input  logic [M_AXI_DATA_WIDTH-1:0]     AMCI_WDATA,
  input  logic                            AMCI_WRITE,
  output logic [1:0]                      AMCI_WRESP,
  output logic                            AMCI_WIDLE,
  input  logic [M_AXI_ADDR_WIDTH-1:0]     AMCI_RADDR,
  input  logic                            AMCI_READ,
  output logic [M_AXI_DATA_WIDTH-1:0]     AMCI_RDATA,
  output logic [1:0]                      AMCI_RRESP,
  output logic                            AMCI_RIDLE,
  output logic [M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  output logic [2:0]                      M_AXI_AWPROT,
  input  logic                            M_AXI_AWREADY,
  output logic [M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic                            M_AXI_WVALID,
  output logic [M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  output logic [2:0]                      M_AXI_ARPROT,
  input  logic                            M_AXI_ARREADY,
  input  logic [M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_t;

  w_state_t                      r_wstate, w_wnext;
  r_state_t                      r_rstate, w_rnext;

  logic [M_AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic [M_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic                          r_awvalid, r_wvalid, r_bready, r_widle;
  logic [1:0]                    r_wresp;
  logic                          w_aw_done, w_w_done;

  logic [M_AXI_ADDR_WIDTH-1:0]   r_araddr;
  logic                          r_arvalid, r_rready, r_ridle;
  logic [M_AXI_DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]                    r_rresp;

  // ---------------- write engine ----------------
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) r_wstate <= W_IDLE;
    else              r_wstate <= w_wnext;
  end

  // A channel counts as done in W_XFER if its VALID is already low
  // (completed on an earlier edge) or its handshake happens on this edge,
  // so AW and W may finish in either order or together.
  always_comb begin
    w_wnext   = r_wstate;
    w_aw_done = !r_awvalid || M_AXI_AWREADY;
    w_w_done  = !r_wvalid  || M_AXI_WREADY;
    case (r_wstate)
      W_IDLE:  if (AMCI_WRITE)             w_wnext = W_XFER;
      W_XFER:  if (w_aw_done && w_w_done)  w_wnext = W_RESP;
      W_RESP:  if (M_AXI_BVALID)           w_wnext = W_IDLE;
      default:                             w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_widle   <= 1'b1;
      r_wresp   <= 2'b00;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (AMCI_WRITE) begin
            r_awaddr  <= AMCI_WADDR;
            r_wdata   <= AMCI_WDATA;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_widle   <= 1'b0;
          end
        end
        W_XFER: begin
          if (M_AXI_AWREADY)      r_awvalid <= 1'b0;
          if (M_AXI_WREADY)       r_wvalid  <= 1'b0;
          if (w_wnext == W_RESP)  r_bready  <= 1'b1;
        end
        W_RESP: begin
          if (M_AXI_BVALID) begin
            r_wresp  <= M_AXI_BRESP;
            r_bready <= 1'b0;
            r_widle  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- read engine ----------------
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) r_rstate <= R_IDLE;
    else              r_rstate <= w_rnext;
  end

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (AMCI_READ)     w_rnext = R_ADDR;
      R_ADDR:  if (M_AXI_ARREADY) w_rnext = R_DATA;
      R_DATA:  if (M_AXI_RVALID)  w_rnext = R_IDLE;
      default:                    w_rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      r_araddr  <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_ridle   <= 1'b1;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (AMCI_READ) begin
            r_araddr  <= AMCI_RADDR;
            r_arvalid <= 1'b1;
            r_ridle   <= 1'b0;
          end
        end
        R_ADDR: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        R_DATA: begin
          if (M_AXI_RVALID) begin
            r_rdata  <= M_AXI_RDATA;
            r_rresp  <= M_AXI_RRESP;
            r_rready <= 1'b0;
            r_ridle  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign AMCI_WRESP    = r_wresp;
  assign AMCI_WIDLE    = r_widle;
  assign AMCI_RDATA    = r_rdata;
  assign AMCI_RRESP    = r_rresp;
  assign AMCI_RIDLE    = r_ridle;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = r_rready;

endmodule
